// File: rtl/sim_stop_ctrl.sv
// Simulation run controller: stops on all-done plus drain, hard timeout or idle watchdog,
// and reports why and when so a testbench can check its own run length.
module sim_stop_ctrl #(
    parameter int              N            = 1,
    parameter int              CW           = 32,
    parameter longint unsigned CYCLES       = 50000000,
    parameter longint unsigned IDLE_CYCLES  = 0,
    parameter longint unsigned DRAIN_CYCLES = 16,
    parameter bit              FINISH       = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          enable,
    input  logic [N-1:0]  activity,
    input  logic [N-1:0]  done,
    output logic          stopped,
    output logic          stop_pulse,
    output logic [1:0]    reason,
    output logic [CW-1:0] cycles,
    output logic [N-1:0]  done_seen
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        STOPPED
    } state_t;

    localparam logic [1:0] REASON_DONE    = 2'd1;
    localparam logic [1:0] REASON_TIMEOUT = 2'd2;
    localparam logic [1:0] REASON_IDLE    = 2'd3;

    localparam bit            TIMEOUT_EN = (CYCLES != 64'd0);
    localparam bit            IDLE_EN    = (IDLE_CYCLES != 64'd0);
    localparam bit            DRAIN_EN   = (DRAIN_CYCLES != 64'd0);
    localparam logic [CW-1:0] CYC_LIM    = CW'(CYCLES - 64'd1);
    localparam logic [CW-1:0] IDLE_LIM   = CW'(IDLE_CYCLES - 64'd1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 64'd1);

    // Limits are compared at CW bits, so anything wider is a configuration error.
    if (CW < 64) begin : g_width_check
        if (((CYCLES >> CW) != 64'd0) || ((IDLE_CYCLES >> CW) != 64'd0) ||
            ((DRAIN_CYCLES >> CW) != 64'd0)) begin : g_bad_cfg
            $error("sim_stop_ctrl: CYCLES/IDLE_CYCLES/DRAIN_CYCLES do not fit in CW bits");
        end
    end

    state_t        state;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] drain_cnt;

    logic          all_done;
    logic          timeout_hit;
    logic          idle_hit;
    logic [CW-1:0] cycles_next;
    logic [CW-1:0] idle_next;

    // The done term includes this cycle's strobes so a late done is not lost.
    assign all_done    = &(done_seen | done);
    assign timeout_hit = TIMEOUT_EN && (cycles >= CYC_LIM);
    assign idle_hit    = IDLE_EN && (idle_cnt >= IDLE_LIM) && !(|activity);
    assign cycles_next = (cycles == '1) ? cycles : cycles + CW'(1);
    assign idle_next   = (idle_cnt == '1) ? idle_cnt : idle_cnt + CW'(1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= RUN;
            stopped    <= 1'b0;
            stop_pulse <= 1'b0;
            reason     <= 2'd0;
            cycles     <= '0;
            done_seen  <= '0;
            idle_cnt   <= '0;
            drain_cnt  <= '0;
        end else begin
            // The pulse lasts one clock even if enable drops right after the stop.
            stop_pulse <= 1'b0;
            if (enable) begin
                case (state)
                    RUN: begin
                        cycles    <= cycles_next;
                        done_seen <= done_seen | done;
                        idle_cnt  <= (|activity) ? '0 : idle_next;
                        if (timeout_hit) begin
                            state      <= STOPPED;
                            stopped    <= 1'b1;
                            stop_pulse <= 1'b1;
                            reason     <= REASON_TIMEOUT;
                        end else if (idle_hit) begin
                            state      <= STOPPED;
                            stopped    <= 1'b1;
                            stop_pulse <= 1'b1;
                            reason     <= REASON_IDLE;
                        end else if (all_done && !DRAIN_EN) begin
                            state      <= STOPPED;
                            stopped    <= 1'b1;
                            stop_pulse <= 1'b1;
                            reason     <= REASON_DONE;
                        end else if (all_done) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                    DRAIN: begin
                        cycles    <= cycles_next;
                        done_seen <= done_seen | done;
                        if (timeout_hit) begin
                            state      <= STOPPED;
                            stopped    <= 1'b1;
                            stop_pulse <= 1'b1;
                            reason     <= REASON_TIMEOUT;
                        end else if (drain_cnt == '0) begin
                            state      <= STOPPED;
                            stopped    <= 1'b1;
                            stop_pulse <= 1'b1;
                            reason     <= REASON_DONE;
                        end else begin
                            drain_cnt <= drain_cnt - CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    if (FINISH) begin : g_finish
        always @(posedge clk) begin
            if (stopped) begin
                $display("STOPPING SIMULATION: reason=%0d cycles=%0d", reason, cycles);
                $finish;
            end
        end
    end

endmodule

// File: tb/tb_sim_stop_ctrl.sv
// Scoreboard bench for sim_stop_ctrl: four instances with different limits, one run at a time,
// expected stop records queued by the stimulus and checked by a monitor on stop_pulse.
module tb_sim_stop_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn      [4];
    logic        en        [4];
    logic [1:0]  act       [4];
    logic [1:0]  dn        [4];
    logic        stp       [4];
    logic        pls       [4];
    logic [1:0]  rsn       [4];
    logic [31:0] cyc       [4];
    logic [1:0]  dseen     [4];
    int          edge_cnt  [4];

    typedef struct {
        int          inst;
        logic [1:0]  reason;
        logic [31:0] cycles;
        logic [1:0]  done_seen;
        int          edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    sim_stop_ctrl #(.N(2), .CW(32), .CYCLES(100), .IDLE_CYCLES(0), .DRAIN_CYCLES(4), .FINISH(0)) u_main (
        .clk(clk), .nreset(rstn[0]), .enable(en[0]), .activity(act[0]), .done(dn[0]),
        .stopped(stp[0]), .stop_pulse(pls[0]), .reason(rsn[0]), .cycles(cyc[0]), .done_seen(dseen[0]));

    sim_stop_ctrl #(.N(2), .CW(32), .CYCLES(0), .IDLE_CYCLES(8), .DRAIN_CYCLES(16), .FINISH(0)) u_idle (
        .clk(clk), .nreset(rstn[1]), .enable(en[1]), .activity(act[1]), .done(dn[1]),
        .stopped(stp[1]), .stop_pulse(pls[1]), .reason(rsn[1]), .cycles(cyc[1]), .done_seen(dseen[1]));

    sim_stop_ctrl #(.N(2), .CW(32), .CYCLES(30), .IDLE_CYCLES(0), .DRAIN_CYCLES(20), .FINISH(0)) u_race (
        .clk(clk), .nreset(rstn[2]), .enable(en[2]), .activity(act[2]), .done(dn[2]),
        .stopped(stp[2]), .stop_pulse(pls[2]), .reason(rsn[2]), .cycles(cyc[2]), .done_seen(dseen[2]));

    sim_stop_ctrl #(.N(2), .CW(32), .CYCLES(50), .IDLE_CYCLES(0), .DRAIN_CYCLES(16), .FINISH(0)) u_pause (
        .clk(clk), .nreset(rstn[3]), .enable(en[3]), .activity(act[3]), .done(dn[3]),
        .stopped(stp[3]), .stop_pulse(pls[3]), .reason(rsn[3]), .cycles(cyc[3]), .done_seen(dseen[3]));

    // Wall-clock edge number since reset release, per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            edge_cnt[i] <= (rstn[i] === 1'b1) ? edge_cnt[i] + 1 : 0;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [1:0] a, input logic [1:0] d, input logic e);
        act[i] = a;
        dn[i]  = d;
        en[i]  = e;
    endtask

    task automatic wait_edge(input int i, input int e);
        while (edge_cnt[i] < e) @(negedge clk);
    endtask

    task automatic start_run(input int i);
        rstn[i] = 1'b0;
        apply_stimulus(i, 2'b00, 2'b00, 1'b1);
        repeat (2) @(negedge clk);
        check_output($sformatf("reset_stopped_%0d", i), stp[i], 0);
        check_output($sformatf("reset_reason_%0d", i), rsn[i], 0);
        check_output($sformatf("reset_cycles_%0d", i), cyc[i], 0);
        check_output($sformatf("reset_done_seen_%0d", i), dseen[i], 0);
        rstn[i] = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic [1:0] r, input logic [31:0] c,
                            input logic [1:0] d, input int e);
        exp_t x;
        x.inst = i; x.reason = r; x.cycles = c; x.done_seen = d; x.edge_no = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_stop(input int i, input int bound);
        int n = 0;
        while (stp[i] !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("stop_reached_%0d", i), stp[i] === 1'b1, 1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every stop_pulse pops one expected record; the following cycle must drop the pulse.
    initial begin
        bit   pulse_seen [4];
        exp_t x;
        for (int i = 0; i < 4; i++) pulse_seen[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (pulse_seen[i]) begin
                    check_output($sformatf("pulse_low_%0d", i), pls[i], 0);
                    check_output($sformatf("stays_stopped_%0d", i), stp[i], 1);
                    pulse_seen[i] = 1'b0;
                end else if (pls[i] === 1'b1) begin
                    check_output($sformatf("expected_stop_%0d", i), exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        x = exp_q.pop_front();
                        check_output($sformatf("stop_inst_%0d", i), i, x.inst);
                        check_output($sformatf("stop_reason_%0d", i), rsn[i], x.reason);
                        check_output($sformatf("stop_cycles_%0d", i), cyc[i], x.cycles);
                        check_output($sformatf("stop_done_seen_%0d", i), dseen[i], x.done_seen);
                        check_output($sformatf("stop_edge_%0d", i), edge_cnt[i], x.edge_no);
                        check_output($sformatf("stop_flag_%0d", i), stp[i], 1);
                    end
                    pulse_seen[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rstn[i] = 1'b0;
            apply_stimulus(i, 2'b00, 2'b00, 1'b1);
        end

        // Plain timeout: 100 enabled edges with no done.
        $display("[TB] timeout run");
        start_run(0);
        push_exp(0, 2'd2, 32'd100, 2'b00, 100);
        wait_stop(0, 150);

        // done[0] before edge 10, done[1] before edge 20: DRAIN from edge 20, stop after edge 24.
        $display("[TB] all-done with drain");
        start_run(0);
        wait_edge(0, 9);  apply_stimulus(0, 2'b00, 2'b01, 1'b1);
        wait_edge(0, 10); apply_stimulus(0, 2'b00, 2'b00, 1'b1);
        wait_edge(0, 19); apply_stimulus(0, 2'b00, 2'b10, 1'b1);
        push_exp(0, 2'd1, 32'd24, 2'b11, 24);
        wait_edge(0, 20); apply_stimulus(0, 2'b00, 2'b00, 1'b1);
        check_output("drain_not_stopped", stp[0], 0);
        check_output("drain_cycles", cyc[0], 20);
        check_output("drain_done_seen", dseen[0], 2'b11);
        wait_stop(0, 40);

        // Reset while draining clears outputs without a clock edge; next run starts cold.
        $display("[TB] reset during drain");
        start_run(0);
        wait_edge(0, 4); apply_stimulus(0, 2'b00, 2'b11, 1'b1);
        wait_edge(0, 5); apply_stimulus(0, 2'b00, 2'b00, 1'b1);
        wait_edge(0, 6);
        check_output("pre_reset_cycles", cyc[0], 6);
        check_output("pre_reset_done_seen", dseen[0], 2'b11);
        rstn[0] = 1'b0;
        #1;
        check_output("async_reset_stopped", stp[0], 0);
        check_output("async_reset_pulse", pls[0], 0);
        check_output("async_reset_reason", rsn[0], 0);
        check_output("async_reset_cycles", cyc[0], 0);
        check_output("async_reset_done_seen", dseen[0], 0);
        start_run(0);
        push_exp(0, 2'd2, 32'd100, 2'b00, 100);
        wait_stop(0, 150);

        // Idle watchdog: activity on edges 1..5, eighth idle edge is edge 13.
        $display("[TB] idle watchdog");
        start_run(1);
        for (int k = 1; k <= 5; k++) begin
            wait_edge(1, k - 1);
            apply_stimulus(1, (k % 2 == 1) ? 2'b01 : 2'b10, 2'b00, 1'b1);
        end
        wait_edge(1, 5); apply_stimulus(1, 2'b00, 2'b00, 1'b1);
        push_exp(1, 2'd3, 32'd13, 2'b00, 13);
        wait_edge(1, 12);
        check_output("idle_not_yet", stp[1], 0);
        wait_stop(1, 40);

        // All done at edge 20 with a 20-cycle drain: timeout at edge 30 wins.
        $display("[TB] timeout inside drain");
        start_run(2);
        wait_edge(2, 19); apply_stimulus(2, 2'b00, 2'b11, 1'b1);
        wait_edge(2, 20); apply_stimulus(2, 2'b00, 2'b00, 1'b1);
        push_exp(2, 2'd2, 32'd30, 2'b11, 30);
        wait_stop(2, 60);

        // Enable low for edges 11..20 (done ignored meanwhile): timeout lands on wall edge 60.
        $display("[TB] enable pause");
        start_run(3);
        wait_edge(3, 10); apply_stimulus(3, 2'b00, 2'b00, 1'b0);
        wait_edge(3, 12); apply_stimulus(3, 2'b01, 2'b11, 1'b0);
        wait_edge(3, 13); apply_stimulus(3, 2'b00, 2'b00, 1'b0);
        wait_edge(3, 15);
        check_output("pause_cycles_frozen", cyc[3], 10);
        check_output("pause_done_ignored", dseen[3], 0);
        wait_edge(3, 20); apply_stimulus(3, 2'b00, 2'b00, 1'b1);
        push_exp(3, 2'd2, 32'd50, 2'b00, 60);
        wait_stop(3, 100);

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
